// File: rtl/pv_avg_filter.sv
// pv_avg_filter: moving-average filter for the process-variable sample stream.
// Keeps a circular window of 2^DEPTH_LOG2 samples and a running sum, and
// emits the truncated average one clock after each accepted input strobe.
// Optional build macro: PV_FILTER_PRIME_EN -- the first sample after reset
// fills the whole window, so the first output equals that sample.
module pv_avg_filter #(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_stb,
  input  logic [7:0] in_pv,
  output logic       out_stb,
  output logic [7:0] out_pv,
  output logic       out_full
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned SUM_W  = 8 + DEPTH_LOG2;
  localparam int unsigned FILL_W = DEPTH_LOG2 + 1;

  logic [7:0]            r_buf [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [SUM_W-1:0]      r_sum;
  logic [FILL_W-1:0]     r_fill;
  logic                  r_out_stb;
  logic [7:0]            r_out_pv;
  logic                  r_out_full;

  logic [7:0]            w_old;
  logic [SUM_W-1:0]      w_sum_upd;
  logic [SUM_W-1:0]      w_sum_next;
  logic [FILL_W-1:0]     w_fill_upd;
  logic [FILL_W-1:0]     w_fill_next;
  logic                  w_accept;
  logic                  w_prime;

  assign w_accept = in_stb && !reset;
  assign w_old    = r_buf[r_wptr];

  // Running-sum update: the result always fits in SUM_W bits, so modular
  // intermediate arithmetic yields the exact value.
  assign w_sum_upd  = r_sum + SUM_W'(in_pv) - SUM_W'(w_old);
  assign w_fill_upd = (r_fill == FILL_W'(DEPTH)) ? r_fill : r_fill + FILL_W'(1);

`ifdef PV_FILTER_PRIME_EN
  logic r_primed;

  assign w_prime     = in_stb && !r_primed;
  assign w_sum_next  = w_prime ? (SUM_W'(in_pv) << DEPTH_LOG2) : w_sum_upd;
  assign w_fill_next = w_prime ? FILL_W'(DEPTH) : w_fill_upd;

  // Tracks whether the window has been primed since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_primed <= 1'b0;
    end else if (in_stb) begin
      r_primed <= 1'b1;
    end
  end
`else
  assign w_prime     = 1'b0;
  assign w_sum_next  = w_sum_upd;
  assign w_fill_next = w_fill_upd;
`endif

  // Sample window storage; priming broadcasts the first sample to every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[DEPTH_LOG2'(i)] <= 8'h00;
      end
    end else if (in_stb) begin
      if (w_prime) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_buf[DEPTH_LOG2'(i)] <= in_pv;
        end
      end else begin
        r_buf[r_wptr] <= in_pv;
      end
    end
  end

  // Pointer, sum, fill count and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= '0;
      r_sum      <= '0;
      r_fill     <= '0;
      r_out_stb  <= 1'b0;
      r_out_pv   <= 8'h00;
      r_out_full <= 1'b0;
    end else begin
      r_out_stb <= w_accept;
      if (in_stb) begin
        r_wptr     <= r_wptr + DEPTH_LOG2'(1);
        r_sum      <= w_sum_next;
        r_fill     <= w_fill_next;
        r_out_pv   <= 8'(w_sum_next >> DEPTH_LOG2);
        r_out_full <= (w_fill_next == FILL_W'(DEPTH));
      end
    end
  end

  assign out_stb  = r_out_stb;
  assign out_pv   = r_out_pv;
  assign out_full = r_out_full;

endmodule

// File: tb/tb_pv_avg_filter.sv
// Directed testbench for pv_avg_filter with DEPTH_LOG2=2 (window of 4).
// Expected values are hand-computed; the PV_FILTER_PRIME_EN build selects
// the priming expectations.
module tb_pv_avg_filter;

  logic       clk;
  logic       reset;
  logic       in_stb;
  logic [7:0] in_pv;
  logic       out_stb;
  logic [7:0] out_pv;
  logic       out_full;

  int errors = 0;
  int checks = 0;

  pv_avg_filter #(.DEPTH_LOG2(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_stb   (in_stb),
    .in_pv    (in_pv),
    .out_stb  (out_stb),
    .out_pv   (out_pv),
    .out_full (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset  = 1'b1;
    in_stb = 1'b0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // One strobed sample followed by checks of the resulting output cycle.
  task automatic send_check(input string name, input logic [7:0] v,
                            input logic [7:0] exp_pv, input logic exp_full);
    in_stb = 1'b1;
    in_pv  = v;
    tick();
    in_stb = 1'b0;
    in_pv  = 8'hA5;
    checks++;
    if (out_stb !== 1'b1) begin
      errors++;
      $display("FAIL %s out_stb: got %b expected 1", name, out_stb);
    end
    checks++;
    if (out_pv !== exp_pv) begin
      errors++;
      $display("FAIL %s out_pv: got %0d expected %0d", name, out_pv, exp_pv);
    end
    checks++;
    if (out_full !== exp_full) begin
      errors++;
      $display("FAIL %s out_full: got %b expected %b", name, out_full, exp_full);
    end
  endtask

  task automatic test_reset();
    in_pv = 8'h00;
    do_reset(2);
    checks++;
    if (out_stb !== 1'b0 || out_pv !== 8'h00 || out_full !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: got stb=%b pv=%0d full=%b expected 0/0/0",
               out_stb, out_pv, out_full);
    end
  endtask

`ifndef PV_FILTER_PRIME_EN
  task automatic test_fill_ramp();
    do_reset(2);
    send_check("ramp0", 8'd8, 8'd2, 1'b0);
    send_check("ramp1", 8'd8, 8'd4, 1'b0);
    send_check("ramp2", 8'd8, 8'd6, 1'b0);
    send_check("ramp3", 8'd8, 8'd8, 1'b1);
  endtask

  task automatic test_wrap();
    send_check("wrap0", 8'd0, 8'd6, 1'b1);
    send_check("wrap1", 8'd0, 8'd4, 1'b1);
    send_check("wrap2", 8'd0, 8'd2, 1'b1);
    send_check("wrap3", 8'd0, 8'd0, 1'b1);
  endtask
`else
  task automatic test_prime();
    do_reset(2);
    send_check("prime0", 8'd100, 8'd100, 1'b1);
    send_check("prime1", 8'd0, 8'd75, 1'b1);
    send_check("prime2", 8'd0, 8'd50, 1'b1);
  endtask
`endif

  // Idle cycles with a changing in_pv: no strobe, output held.
  task automatic test_idle_hold();
    logic [7:0] held;
    held = out_pv;
    for (int i = 0; i < 3; i++) begin
      in_stb = 1'b0;
      in_pv  = 8'(8'h3C + i * 8'd50);
      tick();
      checks++;
      if (out_stb !== 1'b0 || out_pv !== held) begin
        errors++;
        $display("FAIL idle%0d: got stb=%b pv=%0d expected stb=0 pv=%0d",
                 i, out_stb, out_pv, held);
      end
    end
  endtask

  // Four strobes on consecutive cycles from an all-zero window.
  task automatic test_back_to_back();
    logic [7:0] samp [4];
    logic [7:0] expv [4];
    samp[0] = 8'd255; samp[1] = 8'd255; samp[2] = 8'd255; samp[3] = 8'd1;
    expv[0] = 8'd63;  expv[1] = 8'd127; expv[2] = 8'd191; expv[3] = 8'd191;
    do_reset(1);
`ifdef PV_FILTER_PRIME_EN
    send_check("b2b_prime", 8'd0, 8'd0, 1'b1);
`endif
    in_stb = 1'b1;
    in_pv  = samp[0];
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) in_pv = samp[i+1];
      else       in_stb = 1'b0;
      checks++;
      if (out_stb !== 1'b1 || out_pv !== expv[i]) begin
        errors++;
        $display("FAIL b2b%0d: got stb=%b pv=%0d expected stb=1 pv=%0d",
                 i, out_stb, out_pv, expv[i]);
      end
    end
    tick();
    checks++;
    if (out_stb !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end out_stb: got %b expected 0", out_stb);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1);
`ifdef PV_FILTER_PRIME_EN
    send_check("mid0", 8'd20, 8'd20, 1'b1);
    send_check("mid1", 8'd60, 8'd30, 1'b1);
`else
    send_check("mid0", 8'd20, 8'd5, 1'b0);
    send_check("mid1", 8'd60, 8'd20, 1'b0);
`endif
    in_stb = 1'b1;
    in_pv  = 8'd99;
    reset  = 1'b1;
    tick();
    in_stb = 1'b0;
    reset  = 1'b0;
    checks++;
    if (out_stb !== 1'b0 || out_pv !== 8'h00 || out_full !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got stb=%b pv=%0d full=%b expected 0/0/0",
               out_stb, out_pv, out_full);
    end
    tick();
    checks++;
    if (out_stb !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_late out_stb: got %b expected 0", out_stb);
    end
`ifdef PV_FILTER_PRIME_EN
    send_check("mid_after", 8'd40, 8'd40, 1'b1);
`else
    send_check("mid_after", 8'd40, 8'd10, 1'b0);
`endif
  endtask

  initial begin
    reset  = 1'b1;
    in_stb = 1'b0;
    in_pv  = 8'h00;
    test_reset();
`ifndef PV_FILTER_PRIME_EN
    test_fill_ramp();
    test_wrap();
`else
    test_prime();
`endif
    test_idle_hold();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
